// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register for the 5-stage MIPS CPU.
// Carries NUM_LANES payload lanes plus PC, delay-slot flag, valid and a merged
// exception code. It supports stall (hold), bubble (keep PC/bd for EPC),
// exception flush to the handler, and a saturating bubble counter.
module pipe_stage_reg #(
    parameter int          DATA_W     = 32,
    parameter int          NUM_LANES  = 4,
    parameter int          EXC_W      = 5,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter int          CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        stall,
    input  logic                        clr,
    input  logic                        req,
    input  logic [NUM_LANES*DATA_W-1:0] data_in,
    input  logic [31:0]                 pc_in,
    input  logic                        bd_in,
    input  logic                        valid_in,
    input  logic [EXC_W-1:0]            exc_carry_in,
    input  logic [EXC_W-1:0]            exc_local_in,
    input  logic                        cnt_clr,
    output logic [NUM_LANES*DATA_W-1:0] data_q,
    output logic [31:0]                 pc_q,
    output logic [31:0]                 pc4_q,
    output logic [31:0]                 pc8_q,
    output logic                        bd_q,
    output logic                        valid_q,
    output logic [EXC_W-1:0]            exc_q,
    output logic [CNT_W-1:0]            bubble_cnt
);

    localparam int PAY_W = NUM_LANES * DATA_W;

    logic [EXC_W-1:0] exc_merged;
    logic             cnt_at_max;
    logic             bubble_counted;

    // Merge exception codes: an already-carried (older) code wins over a new one.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path (here the
        // default first); otherwise a latch is inferred.
        exc_merged = exc_local_in;
        if (exc_carry_in != '0) begin
            exc_merged = exc_carry_in;
        end
    end

    // A bubble is counted only when clr actually takes effect (not overridden).
    assign bubble_counted = clr && !req;
    assign cnt_at_max     = (bubble_cnt == {CNT_W{1'b1}});

    // Stage register: reset > flush > bubble > stall > advance.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples pre-edge values; blocking here would create ordering races.
        if (reset) begin
            data_q  <= '0;
            pc_q    <= '0;
            bd_q    <= 1'b0;
            valid_q <= 1'b0;
            exc_q   <= '0;
        end else if (req) begin
            data_q  <= '0;
            pc_q    <= HANDLER_PC;
            bd_q    <= 1'b0;
            valid_q <= 1'b0;
            exc_q   <= '0;
        end else if (clr) begin
            // Bubble keeps PC and bd so a later exception reports the right EPC.
            data_q  <= '0;
            pc_q    <= pc_in;
            bd_q    <= bd_in;
            valid_q <= 1'b0;
            exc_q   <= '0;
        end else if (!stall) begin
            data_q  <= data_in[PAY_W-1:0];
            pc_q    <= pc_in;
            bd_q    <= bd_in;
            valid_q <= valid_in;
            exc_q   <= exc_merged;
        end
    end

    // Saturating bubble counter; a software clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            bubble_cnt <= '0;
        end else if (bubble_counted && !cnt_at_max) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

    // Sequential PCs for link/return addresses; wrap modulo 2^32.
    assign pc4_q = pc_q + 32'd4;
    assign pc8_q = pc_q + 32'd8;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg. A second instance with a
// 2-bit counter exercises bubble counter saturation and clear priority.
module tb_pipe_stage_reg;

    localparam int DATA_W    = 32;
    localparam int NUM_LANES = 4;
    localparam int EXC_W     = 5;
    localparam int PAY_W     = DATA_W * NUM_LANES;

    logic             clk = 1'b0;
    logic             reset, stall, clr, req, cnt_clr;
    logic [PAY_W-1:0] data_in;
    logic [31:0]      pc_in;
    logic             bd_in, valid_in;
    logic [EXC_W-1:0] exc_carry_in, exc_local_in;

    logic [PAY_W-1:0] data_q;
    logic [31:0]      pc_q, pc4_q, pc8_q;
    logic             bd_q, valid_q;
    logic [EXC_W-1:0] exc_q;
    logic [15:0]      bubble_cnt;

    // Small-counter instance: own clr / cnt_clr, never flushed.
    logic             clr_b, cnt_clr_b;
    logic [PAY_W-1:0] b_data_q;
    logic [31:0]      b_pc_q, b_pc4_q, b_pc8_q;
    logic             b_bd_q, b_valid_q;
    logic [EXC_W-1:0] b_exc_q;
    logic [1:0]       b_bubble_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg u_dut (
        .clk(clk), .reset(reset), .stall(stall), .clr(clr), .req(req),
        .data_in(data_in), .pc_in(pc_in), .bd_in(bd_in), .valid_in(valid_in),
        .exc_carry_in(exc_carry_in), .exc_local_in(exc_local_in), .cnt_clr(cnt_clr),
        .data_q(data_q), .pc_q(pc_q), .pc4_q(pc4_q), .pc8_q(pc8_q), .bd_q(bd_q),
        .valid_q(valid_q), .exc_q(exc_q), .bubble_cnt(bubble_cnt)
    );

    pipe_stage_reg #(.CNT_W(2)) u_dut_cnt2 (
        .clk(clk), .reset(reset), .stall(stall), .clr(clr_b), .req(1'b0),
        .data_in(data_in), .pc_in(pc_in), .bd_in(bd_in), .valid_in(valid_in),
        .exc_carry_in(exc_carry_in), .exc_local_in(exc_local_in), .cnt_clr(cnt_clr_b),
        .data_q(b_data_q), .pc_q(b_pc_q), .pc4_q(b_pc4_q), .pc8_q(b_pc8_q), .bd_q(b_bd_q),
        .valid_q(b_valid_q), .exc_q(b_exc_q), .bubble_cnt(b_bubble_cnt)
    );

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [PAY_W-1:0] PAY_A = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h2408_0005};
    localparam logic [PAY_W-1:0] PAY_B = {4{32'hAAAA_5555}};

    initial begin
        reset = 1'b1; stall = 1'b0; clr = 1'b0; req = 1'b0; cnt_clr = 1'b0;
        clr_b = 1'b0; cnt_clr_b = 1'b0;
        data_in = PAY_B; pc_in = 32'h9999_0000; bd_in = 1'b1; valid_in = 1'b1;
        exc_carry_in = 5'd3; exc_local_in = 5'd7;

        // Reset state
        step();
        check("rst_data", data_q, '0);
        check("rst_pc", pc_q, 32'h0);
        check("rst_pc4", pc4_q, 32'h4);
        check("rst_bd", bd_q, 1'b0);
        check("rst_valid", valid_q, 1'b0);
        check("rst_exc", exc_q, 5'd0);
        check("rst_cnt", bubble_cnt, 16'd0);

        // Normal advance
        reset = 1'b0;
        data_in = PAY_A; pc_in = 32'h3000; bd_in = 1'b0; valid_in = 1'b1;
        exc_carry_in = 5'd0; exc_local_in = 5'd0;
        step();
        check("adv_data", data_q, PAY_A);
        check("adv_lane0", data_q[31:0], 32'h2408_0005);
        check("adv_pc", pc_q, 32'h3000);
        check("adv_pc4", pc4_q, 32'h3004);
        check("adv_pc8", pc8_q, 32'h3008);
        check("adv_valid", valid_q, 1'b1);
        check("adv_bd", bd_q, 1'b0);

        // Stall for 3 cycles while inputs change
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in = PAY_B ^ PAY_W'(i); pc_in = 32'h5000 + 32'(i * 4);
            bd_in = 1'b1; valid_in = 1'b0; exc_local_in = 5'd7;
            step();
            check("stall_data", data_q, PAY_A);
            check("stall_pc", pc_q, 32'h3000);
            check("stall_bd", bd_q, 1'b0);
            check("stall_valid", valid_q, 1'b1);
            check("stall_cnt", bubble_cnt, 16'd0);
        end

        // Bubble (overrides stall): PC/bd kept, payload/valid/exc cleared
        clr = 1'b1; pc_in = 32'h3010; bd_in = 1'b1; valid_in = 1'b1; exc_local_in = 5'd10;
        step();
        check("clr_data", data_q, '0);
        check("clr_valid", valid_q, 1'b0);
        check("clr_exc", exc_q, 5'd0);
        check("clr_pc", pc_q, 32'h3010);
        check("clr_bd", bd_q, 1'b1);
        check("clr_cnt", bubble_cnt, 16'd1);

        // Flush beats clr and stall; not counted as a bubble
        req = 1'b1; pc_in = 32'h7000;
        step();
        check("req_pc", pc_q, 32'h4180);
        check("req_pc4", pc4_q, 32'h4184);
        check("req_pc8", pc8_q, 32'h4188);
        check("req_bd", bd_q, 1'b0);
        check("req_exc", exc_q, 5'd0);
        check("req_data", data_q, '0);
        check("req_valid", valid_q, 1'b0);
        check("req_cnt", bubble_cnt, 16'd1);

        // Exception merge: older carried code wins
        req = 1'b0; clr = 1'b0; stall = 1'b0;
        data_in = PAY_A; pc_in = 32'h3020; bd_in = 1'b0; valid_in = 1'b1;
        exc_carry_in = 5'd4; exc_local_in = 5'd10;
        step();
        check("exc_carry", exc_q, 5'd4);
        exc_carry_in = 5'd0; exc_local_in = 5'd12;
        step();
        check("exc_local", exc_q, 5'd12);

        // Stall holds exc_q
        stall = 1'b1; exc_carry_in = 5'd3;
        step();
        check("stall_exc", exc_q, 5'd12);

        // PC wrap
        stall = 1'b0; exc_carry_in = 5'd0; exc_local_in = 5'd0;
        pc_in = 32'hFFFF_FFFC;
        step();
        check("wrap_pc4", pc4_q, 32'h0);
        check("wrap_pc8", pc8_q, 32'h4);

        // cnt_clr alone zeroes the counter
        cnt_clr = 1'b1;
        step();
        check("cntclr_cnt", bubble_cnt, 16'd0);
        cnt_clr = 1'b0;
        clr = 1'b1;
        step();
        check("clr2_cnt", bubble_cnt, 16'd1);

        // Reset wins over stall/clr/req; next cycle follows normal priority
        reset = 1'b1; stall = 1'b1; req = 1'b1; pc_in = 32'h3040;
        step();
        check("rst_mid_pc", pc_q, 32'h0);
        check("rst_mid_cnt", bubble_cnt, 16'd0);
        reset = 1'b0; req = 1'b0; bd_in = 1'b1;
        step();
        check("post_rst_pc", pc_q, 32'h3040);
        check("post_rst_bd", bd_q, 1'b1);
        check("post_rst_cnt", bubble_cnt, 16'd1);
        clr = 1'b0; stall = 1'b0;

        // 2-bit counter saturation, then clear beats increment
        clr_b = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            check("sat_cnt", b_bubble_cnt, (i < 3) ? 2'(i) : 2'd3);
        end
        cnt_clr_b = 1'b1;
        step();
        check("sat_clr_cnt", b_bubble_cnt, 2'd0);
        clr_b = 1'b0; cnt_clr_b = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
